// File: rtl/alu_arbiter_pkg.sv
// Shared state encoding and default widths for the ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_e;

  localparam int DEF_DATA_WIDTH   = 32'd8;
  localparam int DEF_OP_WIDTH     = 32'd2;
  localparam int DEF_RESULT_WIDTH = 32'd16;
  localparam int TCOUNT_WIDTH     = 32'd8;

endpackage

// File: rtl/alu_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Walk the requesters starting from the pointer and keep the first hit.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_W-1:0];
      if (!any && req[cand_s]) begin
        any         = 1'b1;
        idx         = cand_s;
        gnt[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, single
// outstanding operation, timeout with error response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OP_WIDTH       = DEF_OP_WIDTH,
  parameter int RESULT_WIDTH   = DEF_RESULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clock,
  input  logic                           resetr,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [RESULT_WIDTH-1:0]        rsp_result,
  output logic                           rsp_error,
  output logic [DATA_WIDTH-1:0]          operand_a,
  output logic [DATA_WIDTH-1:0]          operand_b,
  output logic [OP_WIDTH-1:0]            operand,
  output logic                           op_valid,
  input  logic                           operation_done,
  input  logic [RESULT_WIDTH-1:0]        result,
  output logic [TCOUNT_WIDTH-1:0]        timeout_count,
  output logic                           busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_e               state_r, state_s;
  logic [CNT_W-1:0]         wait_cnt_r, wait_cnt_s;
  logic [IDX_W-1:0]         ptr_r, ptr_s;
  logic [IDX_W-1:0]         idx_r, idx_s;
  logic [NUM_REQ-1:0]       grant_r, grant_s;
  logic [NUM_REQ-1:0]       rsp_valid_r, rsp_valid_s;
  logic [RESULT_WIDTH-1:0]  rsp_result_r, rsp_result_s;
  logic                     rsp_error_r, rsp_error_s;
  logic [DATA_WIDTH-1:0]    operand_a_r, operand_a_s;
  logic [DATA_WIDTH-1:0]    operand_b_r, operand_b_s;
  logic [OP_WIDTH-1:0]      operand_r, operand_s;
  logic                     op_valid_r, op_valid_s;
  logic [TCOUNT_WIDTH-1:0]  timeout_count_r, timeout_count_s;
  logic                     busy_r;
  logic [NUM_REQ-1:0]       sel_gnt_s;
  logic [IDX_W-1:0]         sel_idx_s;
  logic                     sel_any_s;
  logic                     timeout_hit_s;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req (req),
    .ptr (ptr_r),
    .gnt (sel_gnt_s),
    .idx (sel_idx_s),
    .any (sel_any_s)
  );

  // The wait counter starts at zero in the op_valid cycle, so the last
  // chance for done is the edge where it holds TIMEOUT_CYCLES-1.
  assign timeout_hit_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_any_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE, WAIT: begin
        if (operation_done || timeout_hit_s) begin
          state_s = RESPOND;
        end else begin
          state_s = WAIT;
        end
      end
      RESPOND: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the datapath and output registers.
  always_comb begin
    grant_s         = '0;
    op_valid_s      = 1'b0;
    rsp_valid_s     = '0;
    rsp_result_s    = rsp_result_r;
    rsp_error_s     = rsp_error_r;
    operand_a_s     = operand_a_r;
    operand_b_s     = operand_b_r;
    operand_s       = operand_r;
    wait_cnt_s      = wait_cnt_r;
    ptr_s           = ptr_r;
    idx_s           = idx_r;
    timeout_count_s = timeout_count_r;
    case (state_r)
      IDLE: begin
        if (sel_any_s) begin
          grant_s     = sel_gnt_s;
          op_valid_s  = 1'b1;
          idx_s       = sel_idx_s;
          wait_cnt_s  = '0;
          operand_a_s = req_a[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          operand_b_s = req_b[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          operand_s   = req_op[int'(sel_idx_s)*OP_WIDTH +: OP_WIDTH];
        end else begin
          idx_s = idx_r;
        end
      end
      ISSUE, WAIT: begin
        if (operation_done) begin
          rsp_result_s       = result;
          rsp_error_s        = 1'b0;
          rsp_valid_s[idx_r] = 1'b1;
        end else if (timeout_hit_s) begin
          rsp_result_s       = '0;
          rsp_error_s        = 1'b1;
          rsp_valid_s[idx_r] = 1'b1;
          if (timeout_count_r != {TCOUNT_WIDTH{1'b1}}) begin
            timeout_count_s = timeout_count_r + TCOUNT_WIDTH'(1);
          end else begin
            timeout_count_s = timeout_count_r;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + CNT_W'(1);
        end
      end
      RESPOND: begin
        if (idx_r == IDX_W'(NUM_REQ - 1)) begin
          ptr_s = '0;
        end else begin
          ptr_s = idx_r + IDX_W'(1);
        end
      end
      default: begin
        ptr_s = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (resetr) begin
      state_r         <= IDLE;
      wait_cnt_r      <= '0;
      ptr_r           <= '0;
      idx_r           <= '0;
      grant_r         <= '0;
      rsp_valid_r     <= '0;
      rsp_result_r    <= '0;
      rsp_error_r     <= 1'b0;
      operand_a_r     <= '0;
      operand_b_r     <= '0;
      operand_r       <= '0;
      op_valid_r      <= 1'b0;
      timeout_count_r <= '0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      wait_cnt_r      <= wait_cnt_s;
      ptr_r           <= ptr_s;
      idx_r           <= idx_s;
      grant_r         <= grant_s;
      rsp_valid_r     <= rsp_valid_s;
      rsp_result_r    <= rsp_result_s;
      rsp_error_r     <= rsp_error_s;
      operand_a_r     <= operand_a_s;
      operand_b_r     <= operand_b_s;
      operand_r       <= operand_s;
      op_valid_r      <= op_valid_s;
      timeout_count_r <= timeout_count_s;
      busy_r          <= (state_s != IDLE);
    end
  end

  assign grant         = grant_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_result    = rsp_result_r;
  assign rsp_error     = rsp_error_r;
  assign operand_a     = operand_a_r;
  assign operand_b     = operand_b_r;
  assign operand       = operand_r;
  assign op_valid      = op_valid_r;
  assign timeout_count = timeout_count_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level reference model compared
// every cycle, plus hand-computed checks for each scenario.
module tb_alu_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int OW = 2;
  localparam int RW = 16;
  localparam int TO = 64;

  logic             clock;
  logic             resetr;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*OW-1:0] req_op;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    rsp_valid;
  logic [RW-1:0]    rsp_result;
  logic             rsp_error;
  logic [DW-1:0]    operand_a;
  logic [DW-1:0]    operand_b;
  logic [OW-1:0]    operand;
  logic             op_valid;
  logic             operation_done;
  logic [RW-1:0]    result;
  logic [7:0]       timeout_count;
  logic             busy;

  alu_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .OP_WIDTH(OW),
    .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .resetr(resetr), .req(req), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .operand_a(operand_a),
    .operand_b(operand_b), .operand(operand), .op_valid(op_valid),
    .operation_done(operation_done), .result(result),
    .timeout_count(timeout_count), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ALU environment: answers alu_lat cycles after op_valid (-1 = never)
  int         alu_lat = -1;
  int         alu_cnt = -1;
  logic [15:0] alu_res = 16'h0000;
  logic       force_done = 1'b0;

  // Reference model: who owns the ALU, when it was issued, response phase
  int         m_owner = -1;
  int         m_issue = 0;
  int         m_ptr   = 0;
  bit         m_resp  = 1'b0;
  logic [3:0]  e_grant = '0, e_rsp_valid = '0;
  logic [15:0] e_result = '0;
  logic        e_err = 1'b0, e_opv = 1'b0, e_busy = 1'b0;
  logic [7:0]  e_a = '0, e_b = '0, e_tc = '0;
  logic [1:0]  e_op = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r, input logic dn,
                            input logic [15:0] res);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_resp = 1'b0;
      e_grant = '0; e_rsp_valid = '0; e_result = '0; e_err = 1'b0; e_opv = 1'b0;
      e_busy = 1'b0; e_a = '0; e_b = '0; e_op = '0; e_tc = '0;
    end else if (m_resp) begin
      e_rsp_valid = '0;
      m_ptr = (m_owner + 1) % NR;
      m_owner = -1;
      m_resp = 1'b0;
      e_busy = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++)
        if (m_owner < 0 && r[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
      if (m_owner >= 0) begin
        m_issue = cyc + 1;
        e_grant = 4'b0001 << m_owner;
        e_opv = 1'b1;
        e_busy = 1'b1;
        e_a = req_a[m_owner*DW +: DW];
        e_b = req_b[m_owner*DW +: DW];
        e_op = req_op[m_owner*OW +: OW];
      end
    end else begin
      e_grant = '0;
      e_opv = 1'b0;
      if (dn) begin
        e_result = res; e_err = 1'b0; e_rsp_valid = 4'b0001 << m_owner; m_resp = 1'b1;
      end else if (cyc - m_issue == TO - 1) begin
        e_result = '0; e_err = 1'b1; e_rsp_valid = 4'b0001 << m_owner; m_resp = 1'b1;
        if (e_tc != 8'd255) e_tc = e_tc + 8'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("grant", 32'(grant), 32'(e_grant));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    chk("rsp_result", 32'(rsp_result), 32'(e_result));
    chk("rsp_error", 32'(rsp_error), 32'(e_err));
    chk("operand_a", 32'(operand_a), 32'(e_a));
    chk("operand_b", 32'(operand_b), 32'(e_b));
    chk("operand", 32'(operand), 32'(e_op));
    chk("op_valid", 32'(op_valid), 32'(e_opv));
    chk("timeout_count", 32'(timeout_count), 32'(e_tc));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic step();
    if (op_valid === 1'b1) alu_cnt = 0;
    else if (alu_cnt >= 0) alu_cnt = alu_cnt + 1;
    operation_done = force_done || (alu_lat >= 0 && alu_cnt == alu_lat);
    result = operation_done ? alu_res : 16'h0000;
    model_edge(resetr, req, operation_done, result);
    @(posedge clock);
    #1;
    cyc = cyc + 1;
    compare_all();
  endtask

  task automatic set_alu(input int lat, input logic [15:0] res);
    alu_lat = lat;
    alu_res = res;
    alu_cnt = -1;
  endtask

  int rr_order[5];
  int rr_exp[5];
  int ng, n_to, t_issue, t_rsp;
  logic [3:0] last_g;
  logic seen0;

  initial begin
    resetr = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0;
    operation_done = 1'b0; result = '0;
    rr_exp = '{0, 1, 2, 3, 0};
    repeat (3) step();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_tcount", 32'(timeout_count), 32'h0);
    resetr = 1'b0;
    step();

    // single request on requester 2
    set_alu(3, 16'h0008);
    req_a[2*DW +: DW] = 8'h05; req_b[2*DW +: DW] = 8'h03; req_op[2*OW +: OW] = 2'b00;
    req = 4'b0100;
    step();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_opvalid", 32'(op_valid), 32'h1);
    chk("single_a", 32'(operand_a), 32'h05);
    chk("single_b", 32'(operand_b), 32'h03);
    req = '0;
    for (int i = 0; i < 20 && rsp_valid == 4'b0000; i++) step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_result", 32'(rsp_result), 32'h0008);
    chk("single_error", 32'(rsp_error), 32'h0);
    repeat (3) step();

    // round robin with all requesters active
    resetr = 1'b1; step(); resetr = 1'b0; step();
    set_alu(1, 16'h0101);
    req_a = 32'h44332211; req_b = 32'h88776655; req_op = 8'b11100100;
    for (int i = 0; i < 5; i++) rr_order[i] = -1;
    ng = 0; last_g = '0;
    req = 4'b1111;
    for (int i = 0; i < 60 && ng < 5; i++) begin
      step();
      if (rsp_valid != 4'b0000) chk("rr_rsp_match", 32'(rsp_valid), 32'(last_g));
      if (grant != 4'b0000) begin
        rr_order[ng] = $clog2(grant);
        last_g = grant;
        ng = ng + 1;
      end
    end
    req = '0;
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(rr_order[i]), 32'(rr_exp[i]));
    repeat (6) step();

    // timeout on requester 1, then a stray done
    set_alu(-1, 16'h0000);
    req = 4'b0010;
    t_issue = -1000; t_rsp = -1;
    for (int i = 0; i < 5 && op_valid !== 1'b1; i++) step();
    t_issue = cyc;
    req = '0;
    for (int i = 0; i < 80 && rsp_valid == 4'b0000; i++) step();
    t_rsp = cyc;
    chk("timeout_latency", 32'(t_rsp - t_issue), 32'd64);
    chk("timeout_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("timeout_error", 32'(rsp_error), 32'h1);
    chk("timeout_result", 32'(rsp_result), 32'h0);
    chk("timeout_count1", 32'(timeout_count), 32'h1);
    repeat (4) step();
    force_done = 1'b1; alu_res = 16'hBEEF;
    step();
    force_done = 1'b0; alu_res = 16'h0000;
    step();
    chk("late_done_rsp", 32'(rsp_valid), 32'h0);
    chk("late_done_busy", 32'(busy), 32'h0);
    chk("late_done_result", 32'(rsp_result), 32'h0);

    // zero-latency ALU
    set_alu(0, 16'h00FF);
    req = 4'b0001;
    for (int i = 0; i < 5 && op_valid !== 1'b1; i++) step();
    chk("zl_grant", 32'(grant), 32'h1);
    req = '0;
    step();
    chk("zl_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("zl_result", 32'(rsp_result), 32'h00FF);
    repeat (2) step();

    // reset in the middle of an operation for requester 3
    set_alu(8, 16'h1234);
    req = 4'b1000;
    step();
    chk("rst_grant3", 32'(grant), 32'h8);
    req = '0;
    repeat (2) step();
    resetr = 1'b1; step(); resetr = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_opvalid", 32'(op_valid), 32'h0);
    chk("rst_operand_a", 32'(operand_a), 32'h0);
    chk("rst_operand_b", 32'(operand_b), 32'h0);
    chk("rst_result", 32'(rsp_result), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (10) step();
    req = 4'b1001;
    step();
    chk("rst_ptr_grant0", 32'(grant), 32'h1);
    set_alu(1, 16'h0042);
    req = 4'b1000;
    for (int i = 0; i < 10 && grant != 4'b1000; i++) step();
    chk("rst_then_grant3", 32'(grant), 32'h8);
    req = '0;
    repeat (6) step();

    // withdrawal: requester 0 pulses while requester 1 is served
    set_alu(2, 16'h0077);
    req = 4'b0010;
    step();
    chk("wd_grant1", 32'(grant), 32'h2);
    req = 4'b0001;
    step();
    req = '0;
    seen0 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (grant[0] === 1'b1) seen0 = 1'b1;
    end
    chk("wd_never_granted0", 32'(seen0), 32'h0);

    // saturation of the timeout counter
    set_alu(-1, 16'h0000);
    req = 4'b0100;
    n_to = 0;
    for (int i = 0; i < 18000 && n_to < 260; i++) begin
      step();
      if (rsp_valid != 4'b0000) n_to = n_to + 1;
    end
    req = '0;
    repeat (3) step();
    chk("sat_timeouts", 32'(n_to), 32'd260);
    chk("sat_tcount", 32'(timeout_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
